fetch_sequencer: RTL and testbench

//   Owns the fetch PC in front of the instruction memory and sequences it each cycle.

---
 rtl/fetch_sequencer_if.sv | 23 ++
 rtl/fetch_sequencer.sv | 57 +++++
 tb/tb_fetch_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: fetch control inputs and PC/status outputs of the fetch sequencer
interface fetch_sequencer_if;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] pc;
  logic [11:0] im_addr;
  logic        fetch_adel;
  logic        in_handler;
  logic        flush;
  logic [7:0]  drop_cnt;
  modport master (
    output stall, br_taken, br_target, exc_req, eret, epc,
    input  pc, im_addr, fetch_adel, in_handler, flush, drop_cnt
  );
  modport slave (
    input  stall, br_taken, br_target, exc_req, eret, epc,
    output pc, im_addr, fetch_adel, in_handler, flush, drop_cnt
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch PC sequencing with branch, stall, exception entry and ERET return
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter int          IM_WORDS   = 4096
) (
  input logic              clk,
  input logic              reset,
  fetch_sequencer_if.slave bus
);
  typedef enum logic {RUN = 1'b0, HANDLER = 1'b1} state_t;
  localparam logic [31:0] IM_END = IM_BASE + 32'(4 * IM_WORDS);
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        flush_q, flush_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      flush_q    <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    flush_d    = 1'b0;
    drop_cnt_d = drop_cnt_q;
    if (state_q == RUN && bus.exc_req) begin
      state_d = HANDLER;
      pc_d    = HANDLER_PC;
      flush_d = 1'b1;
    end else if (state_q == HANDLER && bus.eret) begin
      state_d = RUN;
      pc_d    = bus.epc;
      flush_d = 1'b1;
    end else if (!bus.stall) begin
      pc_d = bus.br_taken ? bus.br_target : pc_q + 32'd4;
    end
    // nested exceptions never redirect; they are only tallied
    if (state_q == HANDLER && bus.exc_req && drop_cnt_q != 8'hFF)
      drop_cnt_d = drop_cnt_q + 8'd1;
  end
  assign bus.pc         = pc_q;
  assign bus.im_addr    = pc_q[13:2] - IM_BASE[13:2];
  assign bus.fetch_adel = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q >= IM_END);
  assign bus.in_handler = (state_q == HANDLER);
  assign bus.flush      = flush_q;
  assign bus.drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed plus random stimulus against a behavioural fetch PC model
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  fetch_sequencer_if bus ();
  fetch_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  logic [31:0] m_pc;
  bit          m_hand;
  bit          m_flush;
  int          m_drop;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_step();
    bit was_hand = m_hand;
    if (!reset) begin
      m_pc = 32'h3000; m_hand = 0; m_flush = 0; m_drop = 0;
    end else begin
      m_flush = 0;
      if (bus.exc_req && !was_hand) begin
        m_pc = 32'h4180; m_hand = 1; m_flush = 1;
      end else if (bus.eret && was_hand) begin
        m_pc = bus.epc; m_hand = 0; m_flush = 1;
      end else if (!bus.stall) begin
        m_pc = bus.br_taken ? bus.br_target : m_pc + 32'd4;
      end
      if (bus.exc_req && was_hand) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
    end
  endtask
  task automatic check_all();
    bit adel = (m_pc % 4 != 0) || (m_pc < 32'h3000) || (m_pc >= 32'h7000);
    logic [31:0] idx = ((m_pc - 32'h3000) >> 2) & 32'hFFF;
    chk("pc", bus.pc, m_pc);
    chk("im_addr", {20'd0, bus.im_addr}, idx);
    chk("fetch_adel", {31'd0, bus.fetch_adel}, {31'd0, adel});
    chk("in_handler", {31'd0, bus.in_handler}, {31'd0, m_hand});
    chk("flush", {31'd0, bus.flush}, {31'd0, m_flush});
    chk("drop_cnt", {24'd0, bus.drop_cnt}, 32'(m_drop));
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask
  task automatic drive(input bit st, input bit bt, input logic [31:0] tgt,
                       input bit ex, input bit er, input logic [31:0] ep);
    bus.stall = st; bus.br_taken = bt; bus.br_target = tgt;
    bus.exc_req = ex; bus.eret = er; bus.epc = ep;
  endtask
  task automatic idle();
    drive(0, 0, 32'h0, 0, 0, 32'h0);
  endtask
  logic [31:0] rt, re;
  initial begin
    m_pc = 32'h0; m_hand = 0; m_flush = 0; m_drop = 0;
    reset = 1'b0;
    idle();
    tick();
    chk("reset_pc", bus.pc, 32'h3000);
    chk("reset_flush", {31'd0, bus.flush}, 32'd0);
    reset = 1'b1;
    tick(); tick(); tick();
    chk("seq_pc3", bus.pc, 32'h300C);
    chk("seq_im3", {20'd0, bus.im_addr}, 32'd3);
    // stall with pending branch, landing at 3008 first
    reset = 1'b0; tick(); reset = 1'b1;
    tick(); tick();
    drive(1, 1, 32'h3100, 0, 0, 0);
    tick(); tick();
    chk("stall_hold", bus.pc, 32'h3008);
    drive(0, 1, 32'h3100, 0, 0, 0);
    tick();
    chk("branch_after_stall", bus.pc, 32'h3100);
    drive(0, 1, 32'h3010, 0, 0, 0);
    tick();
    drive(1, 1, 32'h3050, 1, 0, 0);
    tick();
    chk("exc_pc", bus.pc, 32'h4180);
    chk("exc_im", {20'd0, bus.im_addr}, 32'd1120);
    chk("exc_flush", {31'd0, bus.flush}, 32'd1);
    idle();
    tick();
    chk("flush_drop", {31'd0, bus.flush}, 32'd0);
    drive(0, 0, 0, 0, 1, 32'h3014);
    tick();
    chk("eret_pc", bus.pc, 32'h3014);
    chk("eret_hand", {31'd0, bus.in_handler}, 32'd0);
    idle();
    tick();
    // simultaneous exc+eret in handler: ERET wins and the exception is counted
    drive(0, 0, 0, 1, 0, 0); tick();
    drive(0, 0, 0, 1, 1, 32'h3040); tick();
    chk("exc_eret_pc", bus.pc, 32'h3040);
    chk("exc_eret_drop", {24'd0, bus.drop_cnt}, 32'd1);
    drive(0, 0, 0, 1, 0, 0); tick();
    for (int i = 0; i < 300; i++) tick();
    chk("drop_sat", {24'd0, bus.drop_cnt}, 32'd255);
    chk("sat_hand", {31'd0, bus.in_handler}, 32'd1);
    drive(0, 0, 0, 0, 1, 32'h3020); tick();
    // address error boundaries and PC wrap
    drive(0, 1, 32'h3002, 0, 0, 0); tick();
    chk("adel_misalign", {31'd0, bus.fetch_adel}, 32'd1);
    drive(0, 1, 32'h2FFC, 0, 0, 0); tick();
    chk("adel_low", {31'd0, bus.fetch_adel}, 32'd1);
    drive(0, 1, 32'h6FFC, 0, 0, 0); tick();
    chk("adel_top_ok", {31'd0, bus.fetch_adel}, 32'd0);
    idle(); tick();
    chk("adel_high", {31'd0, bus.fetch_adel}, 32'd1);
    drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0); tick();
    idle(); tick();
    chk("pc_wrap", bus.pc, 32'h0);
    // reset while in handler with five dropped exceptions
    reset = 1'b0; tick(); reset = 1'b1;
    drive(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) tick();
    chk("pre_reset_drop", {24'd0, bus.drop_cnt}, 32'd5);
    idle();
    reset = 1'b0; tick(); reset = 1'b1;
    chk("rst_pc", bus.pc, 32'h3000);
    chk("rst_hand", {31'd0, bus.in_handler}, 32'd0);
    chk("rst_drop", {24'd0, bus.drop_cnt}, 32'd0);
    chk("rst_flush", {31'd0, bus.flush}, 32'd0);
    for (int i = 0; i < 600; i++) begin
      rt = $urandom_range(0, 1) ? 32'h3000 + ($urandom_range(0, 4095) << 2) : $urandom;
      re = $urandom_range(0, 3) != 0 ? 32'h3000 + ($urandom_range(0, 4095) << 2) : $urandom;
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, rt,
            $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, re);
      reset = ($urandom_range(0, 63) != 0);
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
